// File: rtl/instr_fetch_cached_pkg.sv
// Shared definitions for the cached instruction-fetch stage: FSM state
// encoding and address-split width helpers.
package instr_fetch_cached_pkg;

    // Two-state refill FSM, 1-bit encoding.
    typedef enum logic {
        ST_LOOKUP = 1'b0,
        ST_REFILL = 1'b1
    } fetch_state_t;

    // Offset-field width: log2 of words per line.
    function automatic int off_width(input int words);
        return $clog2(words);
    endfunction

    // Index-field width: log2 of cache lines.
    function automatic int idx_width(input int lines);
        return $clog2(lines);
    endfunction

    // Tag-field width: what remains of the word address above index and offset.
    function automatic int tag_width(input int addr_w, input int lines, input int words);
        return addr_w - $clog2(lines) - $clog2(words);
    endfunction

endpackage

// File: rtl/instr_fetch_cached_icache_dm.sv
// Direct-mapped instruction cache storage: data, tag and valid arrays with a
// combinational lookup, a one-word refill write port and a line-validate port.
module icache_dm
    import instr_fetch_cached_pkg::*;
#(
    parameter int LINES   = 16,
    parameter int WORDS   = 4,
    parameter int INSTR_W = 16,
    parameter int TAG_W   = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [idx_width(LINES)-1:0] rd_idx,
    input  logic [off_width(WORDS)-1:0] rd_off,
    input  logic [TAG_W-1:0]         rd_tag,
    output logic [INSTR_W-1:0]       rd_data,
    output logic                     rd_hit,
    input  logic                     wr_en,
    input  logic [idx_width(LINES)-1:0] wr_idx,
    input  logic [off_width(WORDS)-1:0] wr_off,
    input  logic [INSTR_W-1:0]       wr_data,
    input  logic                     val_en,
    input  logic [idx_width(LINES)-1:0] val_idx,
    input  logic [TAG_W-1:0]         val_tag
);

    logic [INSTR_W-1:0] data_mem [LINES][WORDS];
    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [LINES-1:0]   valid;

    // Combinational lookup: a hit needs a valid line with a matching tag.
    always_comb begin
        rd_data = data_mem[rd_idx][rd_off];
        rd_hit  = valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);
    end

    // Refill data write, one word per returned memory beat.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[wr_idx][wr_off] <= wr_data;
        end
    end

    // Tag capture when a completed line is validated.
    always_ff @(posedge clk) begin
        if (val_en) begin
            tag_mem[val_idx] <= val_tag;
        end
    end

    // Valid bits: cleared by reset, set when the last word of a line lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= {LINES{1'b0}};
        end else if (val_en) begin
            valid[val_idx] <= 1'b1;
        end
    end

endmodule

// File: rtl/instr_fetch_cached.sv
// Instruction-fetch stage with a direct-mapped instruction cache. Owns the PC,
// refills a missing line word by word from instruction memory, redirects on a
// taken branch (deferred until the refill finishes) and holds on stall.
module instr_fetch_cached
    import instr_fetch_cached_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = 16,
    parameter int                LINES    = 16,
    parameter int                WORDS    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               PC_src,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic [INSTR_W-1:0] instr_fetch_out,
    output logic [ADDR_W-1:0]  pc_fetch_out,
    output logic               fetch_valid,
    output logic               hit_fetch_out,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               mem_rvalid
);

    localparam int OW = off_width(WORDS);
    localparam int IW = idx_width(LINES);
    localparam int TW = tag_width(ADDR_W, LINES, WORDS);
    localparam logic [OW-1:0] CNT_LAST = OW'(WORDS - 1);

    fetch_state_t       state;
    logic [ADDR_W-1:0]  pc;
    logic [OW-1:0]      cnt;
    logic               pend_valid;
    logic [ADDR_W-1:0]  pend_target;

    logic [OW-1:0]      off_s;
    logic [IW-1:0]      idx_s;
    logic [TW-1:0]      tag_s;
    logic [INSTR_W-1:0] rd_data_s;
    logic               rd_hit_s;
    logic               wr_en_s;
    logic               last_s;

    // Address split of the current PC and refill write qualifiers.
    always_comb begin
        off_s   = pc[OW-1:0];
        idx_s   = pc[OW+IW-1:OW];
        tag_s   = pc[ADDR_W-1:OW+IW];
        wr_en_s = (state == ST_REFILL) && mem_rvalid;
        last_s  = wr_en_s && (cnt == CNT_LAST);
    end

    icache_dm #(
        .LINES   (LINES),
        .WORDS   (WORDS),
        .INSTR_W (INSTR_W),
        .TAG_W   (TW)
    ) u_icache (
        .clk     (clk),
        .rst     (rst),
        .rd_idx  (idx_s),
        .rd_off  (off_s),
        .rd_tag  (tag_s),
        .rd_data (rd_data_s),
        .rd_hit  (rd_hit_s),
        .wr_en   (wr_en_s),
        .wr_idx  (idx_s),
        .wr_off  (cnt),
        .wr_data (mem_rdata),
        .val_en  (last_s),
        .val_idx (idx_s),
        .val_tag (tag_s)
    );

    // PC, pending redirect, refill FSM and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_LOOKUP;
            pc              <= RESET_PC;
            cnt             <= {OW{1'b0}};
            pend_valid      <= 1'b0;
            pend_target     <= {ADDR_W{1'b0}};
            instr_fetch_out <= {INSTR_W{1'b0}};
            pc_fetch_out    <= {ADDR_W{1'b0}};
            fetch_valid     <= 1'b0;
            hit_fetch_out   <= 1'b0;
            mem_req         <= 1'b0;
            mem_addr        <= {ADDR_W{1'b0}};
        end else begin
            case (state)
                ST_LOOKUP: begin
                    if (PC_src) begin
                        pc            <= branch_target;
                        fetch_valid   <= 1'b0;
                        hit_fetch_out <= 1'b0;
                    end else if (!stall) begin
                        if (rd_hit_s) begin
                            instr_fetch_out <= rd_data_s;
                            pc_fetch_out    <= pc;
                            fetch_valid     <= 1'b1;
                            hit_fetch_out   <= 1'b1;
                            pc              <= pc + ADDR_W'(1);
                        end else begin
                            fetch_valid   <= 1'b0;
                            hit_fetch_out <= 1'b0;
                            cnt           <= {OW{1'b0}};
                            mem_req       <= 1'b1;
                            mem_addr      <= {pc[ADDR_W-1:OW], {OW{1'b0}}};
                            state         <= ST_REFILL;
                        end
                    end
                end
                ST_REFILL: begin
                    // A branch during refill is remembered; the latest one wins.
                    if (PC_src) begin
                        pend_valid  <= 1'b1;
                        pend_target <= branch_target;
                    end
                    if (mem_rvalid) begin
                        if (cnt == CNT_LAST) begin
                            cnt        <= {OW{1'b0}};
                            mem_req    <= 1'b0;
                            state      <= ST_LOOKUP;
                            pend_valid <= 1'b0;
                            if (PC_src) begin
                                pc <= branch_target;
                            end else if (pend_valid) begin
                                pc <= pend_target;
                            end
                        end else begin
                            cnt      <= cnt + OW'(1);
                            mem_addr <= {pc[ADDR_W-1:OW], cnt + OW'(1)};
                        end
                    end
                end
                default: begin
                    state       <= ST_LOOKUP;
                    mem_req     <= 1'b0;
                    fetch_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_cached.sv
// Directed self-checking bench for instr_fetch_cached. Memory returns word k as
// 16'hA000+k, one word per cycle while mem_req is high.
module tb_instr_fetch_cached;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        PC_src;
    logic [15:0] branch_target;
    logic [15:0] instr_fetch_out;
    logic [15:0] pc_fetch_out;
    logic        fetch_valid;
    logic        hit_fetch_out;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata;
    logic        mem_rvalid;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign mem_rvalid = mem_req;
    assign mem_rdata  = 16'hA000 + mem_addr;

    instr_fetch_cached dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .PC_src          (PC_src),
        .branch_target   (branch_target),
        .instr_fetch_out (instr_fetch_out),
        .pc_fetch_out    (pc_fetch_out),
        .fetch_valid     (fetch_valid),
        .hit_fetch_out   (hit_fetch_out),
        .mem_req         (mem_req),
        .mem_addr        (mem_addr),
        .mem_rdata       (mem_rdata),
        .mem_rvalid      (mem_rvalid)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a refill to start, then check the word addresses.
    task automatic expect_refill(input logic [15:0] base, input logic hold);
        int n = 0;
        while (mem_req !== 1'b1 && n < 8) begin
            step();
            n++;
            chk("miss_bubble", 32'(fetch_valid), 32'd0);
        end
        chk("refill_start", 32'(mem_req), 32'd1);
        stall = hold;
        for (int k = 0; k < 4; k++) begin
            chk("refill_addr", 32'(mem_addr), 32'(base + 16'(k)));
            step();
        end
        stall = 1'b0;
        chk("refill_end", 32'(mem_req), 32'd0);
    endtask

    // One cycle later a hit must present the given pc/instruction.
    task automatic expect_fetch(input logic [15:0] pc, input logic [15:0] ins);
        step();
        chk("fetch_valid", 32'(fetch_valid), 32'd1);
        chk("fetch_hit", 32'(hit_fetch_out), 32'd1);
        chk("fetch_pc", 32'(pc_fetch_out), 32'(pc));
        chk("fetch_instr", 32'(instr_fetch_out), 32'(ins));
        chk("fetch_no_req", 32'(mem_req), 32'd0);
    endtask

    task automatic redirect(input logic [15:0] tgt);
        PC_src        = 1'b1;
        branch_target = tgt;
        step();
        PC_src        = 1'b0;
        chk("redirect_bubble_valid", 32'(fetch_valid), 32'd0);
        chk("redirect_bubble_hit", 32'(hit_fetch_out), 32'd0);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; PC_src = 1'b0; branch_target = 16'h0000;
        step();
        step();
        chk("rst_valid", 32'(fetch_valid), 32'd0);
        chk("rst_hit", 32'(hit_fetch_out), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_pc_out", 32'(pc_fetch_out), 32'd0);
        chk("rst_instr", 32'(instr_fetch_out), 32'd0);
        rst = 1'b0;

        // Cold miss on line 0, then a hit stream.
        expect_refill(16'h0000, 1'b0);
        for (int k = 0; k < 4; k++) expect_fetch(16'(k), 16'hA000 + 16'(k));

        // Sequential run into line 1.
        expect_refill(16'h0004, 1'b0);
        for (int k = 4; k < 8; k++) expect_fetch(16'(k), 16'hA000 + 16'(k));

        // Re-fetch of line 0 hits without a memory request.
        redirect(16'h0000);
        for (int k = 0; k < 5; k++) expect_fetch(16'(k), 16'hA000 + 16'(k));

        // Taken branch in a hit cycle to 0x40 (aliases line 0).
        redirect(16'h0040);
        expect_refill(16'h0040, 1'b0);
        expect_fetch(16'h0040, 16'hA040);
        expect_fetch(16'h0041, 16'hA041);

        // Stall during hits holds the outputs.
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_valid", 32'(fetch_valid), 32'd1);
            chk("stall_pc", 32'(pc_fetch_out), 32'h41);
            chk("stall_instr", 32'(instr_fetch_out), 32'hA041);
        end
        stall = 1'b0;
        expect_fetch(16'h0042, 16'hA042);
        expect_fetch(16'h0043, 16'hA043);

        // Stall during refill does not slow the address sequence.
        expect_refill(16'h0044, 1'b1);
        expect_fetch(16'h0044, 16'hA044);

        // Branch during refill: line 0x08 completes, then the PC goes to 0x10.
        redirect(16'h0008);
        step();
        chk("mid_req", 32'(mem_req), 32'd1);
        chk("mid_addr0", 32'(mem_addr), 32'h08);
        step();
        chk("mid_addr1", 32'(mem_addr), 32'h09);
        PC_src = 1'b1; branch_target = 16'h0030;
        step();
        chk("mid_addr2", 32'(mem_addr), 32'h0A);
        branch_target = 16'h0010;
        step();
        PC_src = 1'b0;
        chk("mid_addr3", 32'(mem_addr), 32'h0B);
        step();
        chk("mid_end_req", 32'(mem_req), 32'd0);
        chk("mid_end_valid", 32'(fetch_valid), 32'd0);
        expect_refill(16'h0010, 1'b0);
        expect_fetch(16'h0010, 16'hA010);
        // The line filled under the pending redirect was validated.
        redirect(16'h0008);
        expect_fetch(16'h0008, 16'hA008);

        // Alias eviction: 0x0000 was replaced by 0x0040.
        redirect(16'h0000);
        expect_refill(16'h0000, 1'b0);
        expect_fetch(16'h0000, 16'hA000);

        // Reset in the middle of a refill.
        redirect(16'h0040);
        step();
        chk("abort_req_before", 32'(mem_req), 32'd1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_req", 32'(mem_req), 32'd0);
        chk("abort_valid", 32'(fetch_valid), 32'd0);
        expect_refill(16'h0000, 1'b0);
        expect_fetch(16'h0000, 16'hA000);
        // The aborted 0x40 line must not have been validated.
        redirect(16'h0040);
        expect_refill(16'h0040, 1'b0);
        expect_fetch(16'h0040, 16'hA040);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
